// File: rtl/keypad_scanner.sv
// 4x5 active-low key matrix scanner with full-scan debounce.
// Emits the lowest pressed code and a level ready that gets a fresh rising edge per accepted key.
module keypad_scanner #(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] row_n,
    input  logic [4:0] col_n,
    output logic [4:0] keycode,
    output logic       ready
);

    typedef enum logic [1:0] {DRIVE0, DRIVE1, DRIVE2, DRIVE3} state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [3:0]  STABLE_MAX  = 4'(DEBOUNCE_SCANS);

    state_t      state_q, state_d;
    logic [15:0] settle_q, settle_d;
    logic [4:0]  col_meta_q, col_meta_d;
    logic [4:0]  col_sync_q, col_sync_d;
    logic [14:0] pressed_q, pressed_d;
    logic [3:0]  row_n_q, row_n_d;
    logic        prev_vld_q, prev_vld_d;
    logic [4:0]  prev_code_q, prev_code_d;
    logic [3:0]  stable_q, stable_d;
    logic        eval_q, eval_d;
    logic        gap_q, gap_d;
    logic [4:0]  keycode_q, keycode_d;
    logic        ready_q, ready_d;

    logic        sample;
    logic [19:0] scan_vec;
    logic        res_vld;
    logic [4:0]  res_code;

    always_comb begin
        col_meta_d  = col_n;
        col_sync_d  = col_meta_q;
        state_d     = state_q;
        settle_d    = settle_q + 16'd1;
        pressed_d   = pressed_q;
        row_n_d     = row_n_q;
        prev_vld_d  = prev_vld_q;
        prev_code_d = prev_code_q;
        stable_d    = stable_q;
        eval_d      = 1'b0;
        gap_d       = 1'b0;
        keycode_d   = keycode_q;
        ready_d     = ready_q;

        sample   = (settle_q == SETTLE_LAST);
        // Row 3 is never stored: it is taken straight from the synchronizer at scan end.
        scan_vec = {~col_sync_q, pressed_q};

        res_vld  = 1'b0;
        res_code = 5'd0;
        for (int i = 19; i >= 0; i--) begin
            if (scan_vec[i]) begin
                res_vld  = 1'b1;
                res_code = 5'(i);
            end
        end

        if (sample) begin
            settle_d = 16'd0;
            state_d  = state_t'(state_q + 2'd1);
            case (state_q)
                DRIVE0:  pressed_d[4:0]   = ~col_sync_q;
                DRIVE1:  pressed_d[9:5]   = ~col_sync_q;
                DRIVE2:  pressed_d[14:10] = ~col_sync_q;
                default: pressed_d        = pressed_q;
            endcase
            case (state_d)
                DRIVE0:  row_n_d = 4'b1110;
                DRIVE1:  row_n_d = 4'b1101;
                DRIVE2:  row_n_d = 4'b1011;
                default: row_n_d = 4'b0111;
            endcase
        end

        if (sample && state_q == DRIVE3) begin
            if ({res_vld, res_code} == {prev_vld_q, prev_code_q}) begin
                stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + 4'd1;
            end else begin
                stable_d = 4'd1;
            end
            prev_vld_d  = res_vld;
            prev_code_d = res_code;
            eval_d      = 1'b1;
        end

        // Acceptance acts one clock after scan end, on the registered debounce state.
        if (gap_q) begin
            ready_d = 1'b1;
        end else if (eval_q && stable_q == STABLE_MAX) begin
            if (!ready_q && prev_vld_q) begin
                keycode_d = prev_code_q;
                ready_d   = 1'b1;
            end else if (ready_q && !prev_vld_q) begin
                ready_d = 1'b0;
            end else if (ready_q && prev_code_q != keycode_q) begin
                keycode_d = prev_code_q;
                ready_d   = 1'b0;
                gap_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DRIVE0;
            settle_q    <= 16'd0;
            col_meta_q  <= 5'h1F;
            col_sync_q  <= 5'h1F;
            pressed_q   <= 15'd0;
            row_n_q     <= 4'b1110;
            prev_vld_q  <= 1'b0;
            prev_code_q <= 5'd0;
            stable_q    <= 4'd0;
            eval_q      <= 1'b0;
            gap_q       <= 1'b0;
            keycode_q   <= 5'd0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            col_meta_q  <= col_meta_d;
            col_sync_q  <= col_sync_d;
            pressed_q   <= pressed_d;
            row_n_q     <= row_n_d;
            prev_vld_q  <= prev_vld_d;
            prev_code_q <= prev_code_d;
            stable_q    <= stable_d;
            eval_q      <= eval_d;
            gap_q       <= gap_d;
            keycode_q   <= keycode_d;
            ready_q     <= ready_d;
        end
    end

    assign row_n   = row_n_q;
    assign keycode = keycode_q;
    assign ready   = ready_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a key-matrix model drives col_n, a state-level model of accepted keys
// queues expected ready edges, and a monitor pops them as the DUT's ready toggles.
module tb_keypad_scanner;

    localparam int SETTLE = 4;
    localparam int DEB    = 2;
    localparam int SCAN   = 4 * SETTLE;

    localparam logic [1:0] EV_RISE = 2'd1;
    localparam logic [1:0] EV_FALL = 2'd2;
    localparam logic [1:0] EV_GAP  = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row_n;
    logic [4:0]  col_n;
    logic [4:0]  keycode;
    logic        ready;

    logic [19:0] keys_held;
    logic        model_ready;
    logic [4:0]  model_code;
    logic [6:0]  exp_q[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SETTLE_CYCLES (SETTLE),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .row_n  (row_n),
        .col_n  (col_n),
        .keycode(keycode),
        .ready  (ready)
    );

    // Passive matrix: a held key pulls its column low while its row is driven.
    always_comb begin
        col_n = 5'h1F;
        for (int r = 0; r < 4; r++) begin
            if (!row_n[r]) begin
                for (int c = 0; c < 5; c++) begin
                    if (keys_held[r * 5 + c]) col_n[c] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    int         cyc_n;
    logic       prev_ready = 1'b0;
    logic       gap_pend   = 1'b0;
    logic [6:0] ev;
    logic [3:0] exp_row;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_n <= 0;
        else        cyc_n <= cyc_n + 1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ready = 1'b0;
            gap_pend   = 1'b0;
        end else begin
            exp_row = ~(4'b0001 << ((cyc_n / SETTLE) % 4));
            check("row_n", 32'(row_n), 32'(exp_row));
            if (gap_pend) begin
                check("gap_len", 32'(ready), 32'd1);
                gap_pend = 1'b0;
            end
            if (ready !== prev_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_edge: ready=%b keycode=%0d, expected no edge at %0t",
                             ready, keycode, $time);
                end else begin
                    ev = exp_q.pop_front();
                    check("edge_dir", 32'(ready), 32'(ev[6:5] == EV_RISE));
                    check("edge_code", 32'(keycode), 32'(ev[4:0]));
                    if (!ready && ev[6:5] == EV_GAP) gap_pend = 1'b1;
                end
            end
            prev_ready = ready;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [5:0] lowest(input logic [19:0] k);
        for (int i = 0; i < 20; i++) begin
            if (k[i]) return {1'b1, 5'(i)};
        end
        return 6'd0;
    endfunction

    task automatic apply_keys(input logic [19:0] k);
        logic [5:0] r;
        r = lowest(k);
        @(negedge clk);
        keys_held = k;
        if (!model_ready && r[5]) begin
            exp_q.push_back({EV_RISE, r[4:0]});
            model_ready = 1'b1;
            model_code  = r[4:0];
        end else if (model_ready && !r[5]) begin
            exp_q.push_back({EV_FALL, model_code});
            model_ready = 1'b0;
        end else if (model_ready && r[4:0] != model_code) begin
            exp_q.push_back({EV_GAP, r[4:0]});
            exp_q.push_back({EV_RISE, r[4:0]});
            model_code = r[4:0];
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected edges still pending after %0d clocks",
                     name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic settle(input string name);
        wait_drain(name, (DEB + 2) * SCAN);
        repeat (2 * SCAN) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [19:0] k;
        int          n;

        rst_n       = 1'b0;
        keys_held   = 20'd0;
        model_ready = 1'b0;
        model_code  = 5'd0;
        repeat (3) @(negedge clk);
        check("reset_row_n", 32'(row_n), 32'h0000000E);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_keycode", 32'(keycode), 32'd0);
        rst_n = 1'b1;

        // Idle scanning: no ready edge allowed for 20 scans.
        repeat (20 * SCAN) @(negedge clk);
        check("idle_ready", 32'(ready), 32'd0);
        check("idle_keycode", 32'(keycode), 32'd0);

        // Single press and release of key 5.
        apply_keys(20'd1 << 5);
        settle("press_5");
        check("held_5_ready", 32'(ready), 32'd1);
        check("held_5_code", 32'(keycode), 32'd5);
        apply_keys(20'd0);
        settle("release_5");
        check("released_5_code", 32'(keycode), 32'd5);

        // Bounce on key 15 flipping every scan so no two scans agree, then a clean hold.
        repeat ($urandom_range(0, SCAN - 1)) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            keys_held = keys_held ^ (20'd1 << 15);
            repeat (SCAN) @(negedge clk);
        end
        check("bounce_ready", 32'(ready), 32'd0);
        apply_keys(20'd1 << 15);
        settle("press_15");
        check("held_15_code", 32'(keycode), 32'd15);
        apply_keys(20'd0);
        settle("release_15");
        apply_keys(20'd1 << 15);
        settle("repress_15");
        apply_keys(20'd0);
        settle("release_15b");

        // Two keys: lowest wins, then releasing it hands over with a one-clock gap.
        apply_keys((20'd1 << 13) | (20'd1 << 7));
        settle("press_7_13");
        check("multi_code", 32'(keycode), 32'd7);
        apply_keys(20'd1 << 13);
        settle("handover_13");
        check("handover_ready", 32'(ready), 32'd1);
        check("handover_code", 32'(keycode), 32'd13);
        apply_keys(20'd0);
        settle("release_13");

        // One-scan glitch on key 19.
        @(negedge clk);
        keys_held = 20'd1 << 19;
        repeat (SCAN) @(negedge clk);
        keys_held = 20'd0;
        repeat (4 * SCAN) @(negedge clk);
        check("glitch_ready", 32'(ready), 32'd0);
        check("glitch_code", 32'(keycode), 32'd13);

        // Random key sets.
        for (int it = 0; it < 12; it++) begin
            k = 20'd0;
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) k[$urandom_range(0, 19)] = 1'b1;
            apply_keys(k);
            settle("random_set");
        end
        apply_keys(20'd0);
        settle("random_release");

        // Asynchronous reset while a key is accepted.
        apply_keys(20'd1 << 11);
        settle("press_11");
        check("pre_reset_ready", 32'(ready), 32'd1);
        repeat ($urandom_range(1, SCAN - 1)) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_ready", 32'(ready), 32'd0);
        check("async_keycode", 32'(keycode), 32'd0);
        check("async_row_n", 32'(row_n), 32'h0000000E);
        model_ready = 1'b0;
        model_code  = 5'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        apply_keys(20'd1 << 11);
        settle("reaccept_11");
        check("reaccept_code", 32'(keycode), 32'd11);
        apply_keys(20'd0);
        settle("final_release");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
